seg_scan: RTL

- Time-multiplexed 8-digit seven-segment display driver; consumes the 32-bit `seg` word produced by the SoC top (confreg) and drives the board anode/cathode pins.
- Each hex nibble of the word is shown on one digit; one digit is lit at a time.
- A frame-aligned shadow register prevents tearing when the value changes mid-scan.

---
 rtl/seg_pkg.sv | 18 +
 rtl/seg_hex_decode.sv | 14 +
 rtl/seg_scan.sv | 108 ++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// seg_pkg: shared constants for the seven-segment scan driver.
// Holds the active-high hex glyph table, digit count and idle pin levels.
package seg_pkg;

    localparam int DIGITS = 8;

    localparam logic [DIGITS-1:0] ANODE_OFF = 8'hFF;
    localparam logic [7:0]        CAT_OFF   = 8'hFF;

    // Active-high segments g..a, indexed by nibble value.
    localparam logic [15:0][6:0] HEX7_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39,
        7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66,
        7'h4F, 7'h5B, 7'h06, 7'h3F
    };

endpackage

// File: rtl/seg_hex_decode.sv
// seg_hex_decode: 4-bit nibble to active-high 7-segment glyph (g..a).
// Ports: nibble (in, 4), segs (out, 7).
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] segs
);

    always_comb begin
        segs = HEX7_TABLE[nibble];
    end

endmodule

// File: rtl/seg_scan.sv
// seg_scan: 8-digit time-multiplexed seven-segment driver with frame shadow.
// Ports: clk, reset (async active-low), en, seg_value[31:0], dp_mask[7:0],
//        an[7:0] (active-low), cat[7:0] (active-low, cat[7]=dp), frame_done.
// Build option: SEG_LEADING_ZERO_BLANK_EN blanks leading zero digits 7..1.
module seg_scan
    import seg_pkg::*;
#(
    parameter int SCAN_DIV = 50000,
    parameter int CNT_W    = 20
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic [31:0]       seg_value,
    input  logic [DIGITS-1:0] dp_mask,
    output logic [DIGITS-1:0] an,
    output logic [7:0]        cat,
    output logic              frame_done
);

    logic [CNT_W-1:0] cnt;
    logic [2:0]       idx;
    logic [39:0]      shadow;

    logic        tick;
    logic        load;
    logic [31:0] eff_val;
    logic [7:0]  eff_dp;
    logic [3:0]  sel_nib;
    logic        sel_dp;
    logic [6:0]  glyph;
    logic        blank_sel;

    assign tick = en && (cnt == CNT_W'(SCAN_DIV - 1));
    assign load = (cnt == '0) && (idx == 3'd0);

    // The output stage sees the incoming word in the load cycle so the
    // first cycle of digit 0 already shows the new frame's value.
    always_comb begin
        eff_val = shadow[39:8];
        eff_dp  = shadow[7:0];
        if (load) begin
            eff_val = seg_value;
            eff_dp  = dp_mask;
        end
        sel_nib = eff_val[{idx, 2'b00} +: 4];
        sel_dp  = eff_dp[idx];
    end

`ifdef SEG_LEADING_ZERO_BLANK_EN
    logic [7:0] blank;
    logic       run;

    // Digit k is blanked when every nibble from 7 down to k is zero.
    always_comb begin
        blank = '0;
        run   = 1'b1;
        for (int k = 7; k >= 1; k--) begin
            run      = run & (eff_val[k*4 +: 4] == 4'h0);
            blank[k] = run;
        end
        blank_sel = blank[idx];
    end
`else
    assign blank_sel = 1'b0;
`endif

    seg_hex_decode u_dec (
        .nibble (sel_nib),
        .segs   (glyph)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt        <= '0;
            idx        <= 3'd0;
            shadow     <= '0;
            an         <= ANODE_OFF;
            cat        <= CAT_OFF;
            frame_done <= 1'b0;
        end else begin
            if (!en) begin
                cnt <= '0;
                idx <= 3'd0;
            end else if (tick) begin
                cnt <= '0;
                idx <= idx + 3'd1;
            end else begin
                cnt <= cnt + 1'b1;
            end

            if (load) begin
                shadow <= {seg_value, dp_mask};
            end

            frame_done <= tick && (idx == 3'd7);

            if (en) begin
                an  <= ~(8'b1 << idx);
                cat <= {~sel_dp, blank_sel ? 7'h7F : ~glyph};
            end else begin
                an  <= ANODE_OFF;
                cat <= CAT_OFF;
            end
        end
    end

endmodule
